// File: rtl/fetch_instruction_pkg.sv
// Shared constants for the instruction-fetch stage.
//   WORD      : instruction width
//   W_ADDR    : word-address width of instruction memory
//   BUF_DEPTH : number of entries in the fetch buffer (deliberately not a power of two)
//   PTR_W     : width of a buffer pointer
//   CNT_W     : width of the buffer occupancy count (holds 0..BUF_DEPTH)
package fetch_instruction_pkg;

  localparam int WORD      = 32;
  localparam int W_ADDR    = 16;
  localparam int BUF_DEPTH = 3;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 2;

  // Advance a buffer pointer, wrapping from the last entry back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {instruction, pc} pairs sitting between instruction memory
// and decode.
//   clk, reset    : clock, synchronous active-high reset
//   flush_i       : drop all entries (redirect); overrides push and pop
//   push_i        : write {push_inst_i, push_pc_i} at the tail
//   pop_i         : retire the head entry
//   count_o       : current occupancy (0..BUF_DEPTH)
//   head_inst_o   : instruction at the head (meaningful only when count_o != 0)
//   head_pc_o     : address of head_inst_o
// The caller must never push while full; the fetch credit logic ensures it.
module fetch_buffer
  import fetch_instruction_pkg::*;
#(
  parameter int P_WORD   = WORD,
  parameter int P_W_ADDR = W_ADDR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [P_WORD-1:0]   push_inst_i,
  input  logic [P_W_ADDR-1:0] push_pc_i,
  input  logic                pop_i,
  output logic [CNT_W-1:0]    count_o,
  output logic [P_WORD-1:0]   head_inst_o,
  output logic [P_W_ADDR-1:0] head_pc_o
);

  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [P_WORD-1:0]   inst_q [BUF_DEPTH];
  logic [P_W_ADDR-1:0] pc_q   [BUF_DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      // Simultaneous push and pop cancel out.
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset: contents are don't-care while empty.
  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    logic we;
    assign we = push_i && !flush_i && (wr_ptr_q == PTR_W'(gi));
    always_ff @(posedge clk) begin
      if (we) begin
        inst_q[gi] <= push_inst_i;
        pc_q[gi]   <= push_pc_i;
      end
    end
  end

  assign count_o     = count_q;
  assign head_inst_o = inst_q[rd_ptr_q];
  assign head_pc_o   = pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_instruction.sv
// Instruction-fetch stage: owns the PC, issues one word read per cycle to a
// single-cycle instruction memory, buffers returned words so a decode stall
// never loses one, and discards stale words on a taken-branch redirect.
//   clk, reset             : clock, synchronous active-high reset
//   stall_i                : decode cannot accept the head this cycle
//   br_i, br_addr_i        : redirect request and its target (wins over all)
//   imem_req_o, imem_addr_o: read request and address (the current PC)
//   imem_rvalid_i/rdata_i  : read response, one cycle after the request
//   v_o, inst_o, pc_o      : head of the fetch buffer toward decode
module fetch_instruction
  import fetch_instruction_pkg::*;
#(
  parameter int                 P_WORD   = WORD,
  parameter int                 P_W_ADDR = W_ADDR,
  parameter logic [P_W_ADDR-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                br_i,
  input  logic [P_W_ADDR-1:0] br_addr_i,
  output logic                imem_req_o,
  output logic [P_W_ADDR-1:0] imem_addr_o,
  input  logic                imem_rvalid_i,
  input  logic [P_WORD-1:0]   imem_rdata_i,
  output logic                v_o,
  output logic [P_WORD-1:0]   inst_o,
  output logic [P_W_ADDR-1:0] pc_o
);

  logic [P_W_ADDR-1:0] pc_q, pc_d;
  logic [P_W_ADDR-1:0] req_pc_q, req_pc_d;
  logic                inflight_q, inflight_d;
  logic                drop_q, drop_d;

  logic [CNT_W-1:0]    count;
  logic                issue;
  logic                push;
  logic                pop;

  // Credit check uses only registered state, so stall_i never reaches the
  // request path; an outstanding request reserves its buffer slot.
  assign issue = !reset && !br_i &&
                 ((CNT_W'(1) + count + CNT_W'(inflight_q)) <= (CNT_W + 1)'(BUF_DEPTH));

  assign push  = imem_rvalid_i && inflight_q && !drop_q && !br_i;
  assign v_o   = !reset && (count != '0);
  assign pop   = v_o && !stall_i && !br_i;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    drop_d     = 1'b0;
    if (br_i) begin
      pc_d   = br_addr_i;
      // A response still owed arrives next cycle and must be thrown away.
      drop_d = inflight_q;
    end else if (issue) begin
      pc_d     = pc_q + P_W_ADDR'(1);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_buffer #(
    .P_WORD   (P_WORD),
    .P_W_ADDR (P_W_ADDR)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (br_i),
    .push_i      (push),
    .push_inst_i (imem_rdata_i),
    .push_pc_i   (req_pc_q),
    .pop_i       (pop),
    .count_o     (count),
    .head_inst_o (inst_o),
    .head_pc_o   (pc_o)
  );

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;

endmodule

// File: tb/tb_fetch_instruction.sv
module tb_fetch_instruction;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        br_i;
  logic [15:0] br_addr_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        v_o;
  logic [31:0] inst_o;
  logic [15:0] pc_o;

  always #5 clk = ~clk;

  fetch_instruction #(.RESET_PC(16'h0010)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .br_i          (br_i),
    .br_addr_i     (br_addr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .v_o           (v_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the fetch buffer is an ordered queue of {inst, pc}; an
  // outstanding read holds one slot of the 3-word budget until it returns.
  typedef struct {
    logic [31:0] inst;
    logic [15:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_req_pc;
  bit          m_infl;
  bit          m_drop;

  // Memory environment: answers the DUT's request one cycle later.
  bit          mem_pend;
  logic [31:0] mem_data;

  task automatic step(input bit rst, input bit st, input bit br, input logic [15:0] ba);
    bit exp_v, exp_req, do_pop, do_cap;
    @(negedge clk);
    reset         = rst;
    stall_i       = st;
    br_i          = br;
    br_addr_i     = ba;
    imem_rvalid_i = mem_pend;
    imem_rdata_i  = mem_data;
    #1;
    exp_v   = !rst && (m_q.size() != 0);
    exp_req = !rst && !br && (m_q.size() + int'(m_infl) < 3);
    check_val("v_o", {31'b0, v_o}, {31'b0, exp_v});
    if (exp_v) begin
      check_val("pc_o", {16'b0, pc_o}, {16'b0, m_q[0].pc});
      check_val("inst_o", inst_o, m_q[0].inst);
    end
    check_val("imem_req_o", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (exp_req) check_val("imem_addr_o", {16'b0, imem_addr_o}, {16'b0, m_pc});
    if (dut.push) check_val("push_while_full", {31'b0, dut.count == 2'd3}, 32'd0);
    $display("cyc rst=%0b st=%0b br=%0b req=%0b addr=%h rv=%0b v=%0b pc=%h inst=%h",
             rst, st, br, imem_req_o, imem_addr_o, imem_rvalid_i, v_o, pc_o, inst_o);

    mem_pend = imem_req_o;
    mem_data = {16'h0, imem_addr_o} + 32'h1000;

    if (rst) begin
      m_q.delete();
      m_pc   = 16'h0010;
      m_infl = 0;
      m_drop = 0;
    end else if (br) begin
      m_q.delete();
      m_pc   = ba;
      m_drop = m_infl;
      m_infl = 0;
    end else begin
      do_pop = exp_v && !st;
      do_cap = imem_rvalid_i && m_infl && !m_drop;
      if (do_pop) void'(m_q.pop_front());
      if (do_cap) m_q.push_back('{inst: imem_rdata_i, pc: m_req_pc});
      if (exp_req) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 16'd1;
      end
      m_infl = exp_req;
      m_drop = 0;
    end
  endtask

  initial begin
    reset = 1; stall_i = 0; br_i = 0; br_addr_i = '0;
    imem_rvalid_i = 0; imem_rdata_i = '0;
    mem_pend = 0; mem_data = '0;
    m_pc = 16'h0010; m_req_pc = 16'h0010; m_infl = 0; m_drop = 0;

    // Reset, then cold start: v_o appears two cycles after release.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_val("reset_v", {31'b0, v_o}, 32'd0);
    check_val("reset_req", {31'b0, imem_req_o}, 32'd0);
    step(0, 0, 0, 0);
    check_val("cold_req", {31'b0, imem_req_o}, 32'd1);
    check_val("cold_addr", {16'b0, imem_addr_o}, 32'h10);
    step(0, 0, 0, 0);
    check_val("cold_v1", {31'b0, v_o}, 32'd0);
    step(0, 0, 0, 0);
    check_val("cold_v2", {31'b0, v_o}, 32'd1);
    check_val("cold_pc", {16'b0, pc_o}, 32'h10);
    check_val("cold_inst", inst_o, 32'h1010);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Long stall fills the buffer and blocks requests.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    check_val("stall_noreq", {31'b0, imem_req_o}, 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

    // One-cycle stall leaves 2 buffered plus 1 in flight, then redirect.
    step(0, 1, 0, 0);
    step(0, 0, 1, 16'h0200);
    step(0, 0, 0, 0);
    check_val("br_t1_v", {31'b0, v_o}, 32'd0);
    step(0, 0, 0, 0);
    check_val("br_t2_v", {31'b0, v_o}, 32'd0);
    step(0, 0, 0, 0);
    check_val("br_t3_pc", {16'b0, pc_o}, 32'h200);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Redirect coincident with stall and an arriving response.
    step(0, 1, 1, 16'h0300);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check_val("brst_pc", {16'b0, pc_o}, 32'h300);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // One-cycle reset mid-stream with a request outstanding.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("rst_mid_pc", {16'b0, pc_o}, 32'h10);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // PC wraps from 0xFFFF to 0x0000.
    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("wrap_pc0", {16'b0, pc_o}, 32'hFFFF);
    step(0, 0, 0, 0);
    check_val("wrap_pc1", {16'b0, pc_o}, 32'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit r_rst, r_st, r_br;
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < 40);
      r_br  = ($urandom_range(0, 99) < 6);
      step(r_rst, r_st, r_br, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
